euler_update_unit: RTL
======================

EULER_UPDATE_UNIT -- requirements
Module: euler_update_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, data word width: signed two's complement fixed point.
REQ-002 Parameter ADDRESS_WIDTH, default 4, memory address width.
REQ-003 Parameter FRAC_BITS, default 7, fractional bits of every data word (0.9 = 'b1110011).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  request one update pass; sampled only in IDLE.
REQ-007 step_in  input  WORD_SIZE  step size h, driven by the step module's step_out.
REQ-008 n  input  WORD_SIZE  element count, unsigned.
REQ-009 x_base  input  ADDRESS_WIDTH  base address of current state vector x.
REQ-010 f_base  input  ADDRESS_WIDTH  base address of derivative vector f.
REQ-011 out_base  input  ADDRESS_WIDTH  base address of result vector (x0/x1 slot for step module).
REQ-012 mem_rd_data  input  WORD_SIZE  memory read data, valid one cycle after mem_rd_en.
REQ-013 mem_address  output  ADDRESS_WIDTH  memory address for read or write.
REQ-014 mem_wr_data  output  WORD_SIZE  write data.
REQ-015 mem_rd_en  output  1  read strobe.
REQ-016 mem_wr_en  output  1  write strobe; never asserted with mem_rd_en.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at end of pass.
REQ-019 overflow  output  1  sticky arithmetic overflow flag for current/last pass.

Function
REQ-020 Per element i (0..n-1) SHALL write out[i] = x[i] + ((h * f[i]) >>> FRAC_BITS), full 2*WORD_SIZE signed product, arithmetic shift (floor truncation).
REQ-021 FSM states IDLE, RD_X, RD_F, MUL, WR, DONE; registered outputs derived from state.
REQ-022 IDLE: on start with n != 0 latch h, n, bases, clear index and overflow -> RD_X; with n == 0 clear overflow -> DONE; else stay.
REQ-023 RD_X: mem_address = x_base + index, mem_rd_en = 1 -> RD_F.
REQ-024 RD_F: capture mem_rd_data as x; mem_address = f_base + index, mem_rd_en = 1 -> MUL.
REQ-025 MUL: capture mem_rd_data as f; register shifted product -> WR.
REQ-026 WR: mem_address = out_base + index, mem_wr_en = 1, mem_wr_data = x + product; if index == n-1 -> DONE, else index+1 -> RD_X.
REQ-027 DONE: done = 1 for exactly one cycle -> IDLE.
REQ-028 Latency: start sampled in cycle 0 -> done high in cycle 4n+1 (cycle 1 for n = 0); exactly one write per element.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH; index low bits used.
REQ-030 start while busy SHALL be ignored; step_in, n and bases changing while busy SHALL have no effect.
REQ-031 overflow SHALL set when shifted product exceeds WORD_SIZE signed range or addition overflows; held until next accepted start.
REQ-032 mem_rd_en, mem_wr_en SHALL be 0 in IDLE and DONE.

Reset
REQ-033 rst SHALL force IDLE, index 0, x/f/product/h/n registers 0, all outputs 0 (busy, done, overflow, strobes, address, data).
REQ-034 rst mid-pass SHALL abort with no further writes; no done pulse for the aborted pass.

Configuration
REQ-035 With EULER_SATURATE_EN defined, overflowing product or sum SHALL clamp to max positive / min negative WORD_SIZE value before writing; overflow still set.
REQ-036 Without EULER_SATURATE_EN, results SHALL wrap modulo 2^WORD_SIZE; overflow still set.

Verification
REQ-037 n=1, h=64 (0.5), x=128 (1.0), f=256 (2.0) -> one write of 256 at out_base, done in cycle 5, overflow 0.
REQ-038 n=3, x_base=14, f_base=2, out_base=15 -> reads 14,15,0 / 2,3,4, writes 15,0,1; done in cycle 13.
REQ-039 h=64, x=0, f=0xFF00 (-2.0) -> writes 0xFF80; h=1, f=0xFFFF, x=0 -> writes 0xFFFF (floor).
REQ-040 h=128, f=128, x=0x7FC0 -> overflow=1; writes 0x7FFF with EULER_SATURATE_EN, 0x8040 without.
REQ-041 n=0 -> done in cycle 1, no memory strobes; start pulsed mid-pass ignored; rst in MUL -> no write, busy 0 next cycle.

Source files
------------

// File: rtl/euler_update_unit.sv
// Explicit Euler step engine: out[i] = x[i] + ((h * f[i]) >>> FRAC_BITS) over a shared memory port.
// Define EULER_SATURATE_EN to clamp overflowing products/sums instead of wrapping them.
module euler_update_unit #(
   parameter int WORD_SIZE     = 16,
   parameter int ADDRESS_WIDTH = 4,
   parameter int FRAC_BITS     = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WORD_SIZE-1:0]     step_in,
   input  logic [WORD_SIZE-1:0]     n,
   input  logic [ADDRESS_WIDTH-1:0] x_base,
   input  logic [ADDRESS_WIDTH-1:0] f_base,
   input  logic [ADDRESS_WIDTH-1:0] out_base,
   input  logic [WORD_SIZE-1:0]     mem_rd_data,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [WORD_SIZE-1:0]     mem_wr_data,
   output logic                     mem_rd_en,
   output logic                     mem_wr_en,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam int PW = 2 * WORD_SIZE;
   localparam logic signed [WORD_SIZE-1:0] W_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [WORD_SIZE-1:0] W_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_RD_X, S_RD_F, S_MUL, S_WR, S_DONE} state_t;

   state_t                        r_state, w_state_next;
   logic signed [WORD_SIZE-1:0]   r_h, r_x, r_prod;
   logic [WORD_SIZE-1:0]          r_n, r_index;
   logic [ADDRESS_WIDTH-1:0]      r_x_base, r_f_base, r_out_base;
   logic                          r_overflow;

   logic signed [PW-1:0]          w_full, w_shift;
   logic                          w_prod_ovf, w_sum_ovf, w_last;
   logic signed [WORD_SIZE-1:0]   w_prod, w_sum;
   logic [WORD_SIZE:0]            w_sum_ext;
   logic [ADDRESS_WIDTH-1:0]      w_idx;

   assign w_idx  = r_index[ADDRESS_WIDTH-1:0];
   assign w_last = (r_index == r_n - 1'b1);

   // Product is formed straight from the returning f word so MUL needs no extra cycle.
   assign w_full     = PW'(r_h) * PW'($signed(mem_rd_data));
   assign w_shift    = w_full >>> FRAC_BITS;
   assign w_prod_ovf = (w_shift[PW-1:WORD_SIZE-1] != {(PW-WORD_SIZE+1){w_shift[PW-1]}});

   assign w_sum_ext  = {r_x[WORD_SIZE-1], r_x} + {r_prod[WORD_SIZE-1], r_prod};
   assign w_sum_ovf  = (w_sum_ext[WORD_SIZE] != w_sum_ext[WORD_SIZE-1]);

`ifdef EULER_SATURATE_EN
   assign w_prod = w_prod_ovf ? (w_shift[PW-1] ? W_MIN : W_MAX) : w_shift[WORD_SIZE-1:0];
   assign w_sum  = w_sum_ovf ? (w_sum_ext[WORD_SIZE] ? W_MIN : W_MAX) : w_sum_ext[WORD_SIZE-1:0];
`else
   assign w_prod = w_shift[WORD_SIZE-1:0];
   assign w_sum  = w_sum_ext[WORD_SIZE-1:0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h        <= '0;
         r_n        <= '0;
         r_x        <= '0;
         r_prod     <= '0;
         r_index    <= '0;
         r_x_base   <= '0;
         r_f_base   <= '0;
         r_out_base <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_overflow <= 1'b0;
               if (n != '0) begin
                  r_h        <= $signed(step_in);
                  r_n        <= n;
                  r_x_base   <= x_base;
                  r_f_base   <= f_base;
                  r_out_base <= out_base;
                  r_index    <= '0;
               end
            end
            S_RD_F: r_x <= $signed(mem_rd_data);
            S_MUL: begin
               r_prod <= w_prod;
               if (w_prod_ovf) r_overflow <= 1'b1;
            end
            S_WR: begin
               if (w_sum_ovf) r_overflow <= 1'b1;
               if (!w_last)   r_index <= r_index + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      mem_address  = '0;
      mem_wr_data  = '0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_next = (n != '0) ? S_RD_X : S_DONE;
         S_RD_X: begin
            mem_address  = r_x_base + w_idx;
            mem_rd_en    = 1'b1;
            w_state_next = S_RD_F;
         end
         S_RD_F: begin
            mem_address  = r_f_base + w_idx;
            mem_rd_en    = 1'b1;
            w_state_next = S_MUL;
         end
         S_MUL: w_state_next = S_WR;
         S_WR: begin
            mem_address  = r_out_base + w_idx;
            mem_wr_data  = w_sum;
            mem_wr_en    = 1'b1;
            w_state_next = w_last ? S_DONE : S_RD_X;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign overflow = r_overflow;

endmodule
